hack_cpu_mc: RTL and testbench

Multi-cycle, parametrised Hack CPU core. Executes the standard 16-bit Hack instruction set over separate instruction and data memory ports with ready/valid-style wait-state handshakes, so it can run from slow or shared memories. Generalises the single-cycle core in three ways:
- configurable data and address width;
- a D register that actually feeds the ALU x input;
- optional halt detection on jump-to-self.

---
 rtl/hack_cpu_mc_pkg.sv | 28 ++
 rtl/hack_cpu_mc_if.sv | 26 ++
 rtl/hack_cpu_mc_alu.sv | 30 +++
 rtl/hack_cpu_mc.sv | 150 +++++++++++++++
 tb/tb_hack_cpu_mc.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hack_cpu_mc_pkg.sv
// Shared types and Hack instruction field positions for the multi-cycle core.
package hack_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    MREAD,
    EXEC,
    MWRITE,
    HALT
  } state_e;

  localparam int CI    = 15;
  localparam int A_SEL = 12;
  localparam int ZX    = 11;
  localparam int NX    = 10;
  localparam int ZY    = 9;
  localparam int NY    = 8;
  localparam int F     = 7;
  localparam int NO    = 6;
  localparam int D_A   = 5;
  localparam int D_D   = 4;
  localparam int D_M   = 3;
  localparam int J_LT  = 2;
  localparam int J_EQ  = 1;
  localparam int J_GT  = 0;

endpackage

// File: rtl/hack_cpu_mc_if.sv
// Instruction and data memory ports with ready-based wait states.
interface hack_cpu_mc_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 15
);
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_req;
  logic [15:0]       imem_rdata;
  logic              imem_ready;
  logic [ADDR_W-1:0] dmem_addr;
  logic              dmem_re;
  logic              dmem_we;
  logic [WIDTH-1:0]  dmem_wdata;
  logic [WIDTH-1:0]  dmem_rdata;
  logic              dmem_ready;

  modport master (
    output imem_addr, imem_req, dmem_addr, dmem_re, dmem_we, dmem_wdata,
    input  imem_rdata, imem_ready, dmem_rdata, dmem_ready
  );

  modport slave (
    input  imem_addr, imem_req, dmem_addr, dmem_re, dmem_we, dmem_wdata,
    output imem_rdata, imem_ready, dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/hack_cpu_mc_alu.sv
// Combinational Hack ALU of arbitrary width; arithmetic wraps modulo 2^WIDTH.
module hack_alu_w #(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] x_i,
  input  logic signed [WIDTH-1:0] y_i,
  input  logic                    zx_i,
  input  logic                    nx_i,
  input  logic                    zy_i,
  input  logic                    ny_i,
  input  logic                    f_i,
  input  logic                    no_i,
  output logic signed [WIDTH-1:0] out_o,
  output logic                    zr_o,
  output logic                    ng_o
);
  logic signed [WIDTH-1:0] xz, xn, yz, yn, fo;

  always_comb begin
    xz    = zx_i ? '0 : x_i;
    xn    = nx_i ? ~xz : xz;
    yz    = zy_i ? '0 : y_i;
    yn    = ny_i ? ~yz : yz;
    fo    = f_i ? (xn + yn) : (xn & yn);
    out_o = no_i ? ~fo : fo;
  end

  assign zr_o = (out_o == '0);
  assign ng_o = out_o[WIDTH-1];
endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU: one FSM walks FETCH/DECODE/MREAD/EXEC/MWRITE, stalling on memory ready.
module hack_cpu_mc
  import hack_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int ADDR_W       = 15,
  parameter int HALT_ON_LOOP = 1
) (
  input  logic           clk,
  input  logic           reset,
  hack_cpu_mc_if.master  bus,
  output logic           retire,
  output logic           halted
);
  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       pc_q, pc_d, pc_inc, target;
  logic signed [WIDTH-1:0] a_q, a_d, d_q, d_d, m_q, m_d, res_q, res_d;
  logic [15:0]             ir_q, ir_d;
  logic                    zr_q, zr_d, ng_q, ng_d;
  logic                    run_q;
  logic signed [WIDTH-1:0] alu_y, alu_out, c_res;
  logic                    alu_zr, alu_ng, c_zr, c_ng, jump, commit;
  logic                    ireq_c, re_c, we_c, retire_c, halted_c;

  // run_q stays low for the cycle after reset so no request escapes it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= '0;
      a_q     <= '0;
      d_q     <= '0;
      ir_q    <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      d_q     <= d_d;
      ir_q    <= ir_d;
      run_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    m_q   <= m_d;
    res_q <= res_d;
    zr_q  <= zr_d;
    ng_q  <= ng_d;
  end

  assign alu_y = ir_q[A_SEL] ? m_q : a_q;

  hack_alu_w #(.WIDTH(WIDTH)) u_alu (
    .x_i  (d_q),
    .y_i  (alu_y),
    .zx_i (ir_q[ZX]),
    .nx_i (ir_q[NX]),
    .zy_i (ir_q[ZY]),
    .ny_i (ir_q[NY]),
    .f_i  (ir_q[F]),
    .no_i (ir_q[NO]),
    .out_o(alu_out),
    .zr_o (alu_zr),
    .ng_o (alu_ng)
  );

  // Commit happens from EXEC (live ALU) or from MWRITE (latched result).
  assign c_res  = (state_q == MWRITE) ? res_q : alu_out;
  assign c_zr   = (state_q == MWRITE) ? zr_q : alu_zr;
  assign c_ng   = (state_q == MWRITE) ? ng_q : alu_ng;
  assign jump   = (ir_q[J_LT] & c_ng) | (ir_q[J_EQ] & c_zr) | (ir_q[J_GT] & ~c_ng & ~c_zr);
  assign pc_inc = pc_q + ADDR_W'(1);
  assign target = a_q[ADDR_W-1:0];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    a_d      = a_q;
    d_d      = d_q;
    ir_d     = ir_q;
    m_d      = m_q;
    res_d    = res_q;
    zr_d     = zr_q;
    ng_d     = ng_q;
    ireq_c   = 1'b0;
    re_c     = 1'b0;
    we_c     = 1'b0;
    retire_c = 1'b0;
    halted_c = 1'b0;
    commit   = 1'b0;
    if (run_q) begin
      case (state_q)
        FETCH: begin
          ireq_c = 1'b1;
          if (bus.imem_ready) begin
            ir_d    = bus.imem_rdata;
            state_d = DECODE;
          end
        end
        DECODE: begin
          if (!ir_q[CI]) begin
            a_d      = WIDTH'(ir_q[14:0]);
            pc_d     = pc_inc;
            retire_c = 1'b1;
            state_d  = FETCH;
          end else begin
            state_d = ir_q[A_SEL] ? MREAD : EXEC;
          end
        end
        MREAD: begin
          re_c = 1'b1;
          if (bus.dmem_ready) begin
            m_d     = bus.dmem_rdata;
            state_d = EXEC;
          end
        end
        EXEC: begin
          res_d = alu_out;
          zr_d  = alu_zr;
          ng_d  = alu_ng;
          if (ir_q[D_M]) state_d = MWRITE;
          else           commit  = 1'b1;
        end
        MWRITE: begin
          we_c = 1'b1;
          if (bus.dmem_ready) commit = 1'b1;
        end
        HALT:    halted_c = 1'b1;
        default: state_d  = FETCH;
      endcase
    end
    if (commit) begin
      if (ir_q[D_A]) a_d = c_res;
      if (ir_q[D_D]) d_d = c_res;
      retire_c = 1'b1;
      pc_d     = jump ? target : pc_inc;
      if ((HALT_ON_LOOP != 0) && jump && (target == pc_q)) state_d = HALT;
      else                                                 state_d = FETCH;
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.imem_req   = ireq_c & reset;
  assign bus.dmem_addr  = a_q[ADDR_W-1:0];
  assign bus.dmem_re    = re_c & reset;
  assign bus.dmem_we    = we_c & reset;
  assign bus.dmem_wdata = res_q;
  assign retire         = retire_c & reset;
  assign halted         = halted_c & reset;
endmodule

// File: tb/tb_hack_cpu_mc.sv
// Directed bench for hack_cpu_mc: behavioural memories with programmable wait states.
module tb_hack_cpu_mc;
  logic clk = 1'b0;
  logic reset;
  logic retire, halted;

  hack_cpu_mc_if #(.WIDTH(16), .ADDR_W(15)) bus ();

  hack_cpu_mc #(.WIDTH(16), .ADDR_W(15), .HALT_ON_LOOP(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .retire(retire),
    .halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0] imem [64];
  logic [15:0] dm   [128];
  int imem_wait = 0, dmem_wait = 0;
  bit iforce = 0, ival = 0, dforce = 0, dval = 0;
  int tests_run = 0, tests_failed = 0;

  // Memory responder: ready asserted after the configured number of wait cycles.
  int icnt = 0, dcnt = 0;
  always @(posedge clk) begin
    #1;
    bus.imem_rdata = imem[bus.imem_addr[5:0]];
    bus.dmem_rdata = dm[bus.dmem_addr[6:0]];
    if (iforce) bus.imem_ready = ival;
    else if (bus.imem_req) begin
      if (icnt >= imem_wait) begin bus.imem_ready = 1'b1; icnt = 0; end
      else begin bus.imem_ready = 1'b0; icnt++; end
    end else begin bus.imem_ready = 1'b0; icnt = 0; end
    if (dforce) bus.dmem_ready = dval;
    else if (bus.dmem_re || bus.dmem_we) begin
      if (dcnt >= dmem_wait) begin bus.dmem_ready = 1'b1; dcnt = 0; end
      else begin bus.dmem_ready = 1'b0; dcnt++; end
    end else begin bus.dmem_ready = 1'b0; dcnt = 0; end
  end

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) imem[i] = 16'h0000;
    for (int i = 0; i < 128; i++) dm[i] = 16'h0000;
    imem_wait = 0; dmem_wait = 0;
    iforce = 0; dforce = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_mem();
    iforce = 1; ival = 1; dforce = 1; dval = 1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if ({bus.imem_req, bus.dmem_re, bus.dmem_we, retire, halted} !== 5'b0) begin
        tests_failed++;
        $display("FAIL reset_outputs cyc%0d: got %b expected 00000", i,
                 {bus.imem_req, bus.dmem_re, bus.dmem_we, retire, halted});
      end
    end
    tests_run++;
    if (dut.pc_q !== 15'd0 || dut.a_q !== 16'd0 || dut.d_q !== 16'd0 || dut.ir_q !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_regs: pc=%0h a=%0h d=%0h ir=%0h expected all 0",
               dut.pc_q, dut.a_q, dut.d_q, dut.ir_q);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({bus.imem_req, bus.dmem_re, bus.dmem_we, retire, halted} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_after_cycle: got %b expected 00000",
               {bus.imem_req, bus.dmem_re, bus.dmem_we, retire, halted});
    end
    iforce = 0; dforce = 0;
    @(negedge clk);
    tests_run++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 15'd0 || halted !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_first_fetch: req=%b addr=%0h halted=%b expected 1 0 0",
               bus.imem_req, bus.imem_addr, halted);
    end
  endtask

  task automatic test_arith();
    int n = 0, r = 0;
    bit started = 0;
    clear_mem();
    imem[0] = 16'h0005; imem[1] = 16'hEC10; imem[2] = 16'h0003; imem[3] = 16'hE090;
    do_reset();
    for (int c = 0; c < 60 && r < 4; c++) begin
      @(negedge clk);
      if (bus.imem_req) started = 1;
      if (started) n++;
      if (retire) r++;
    end
    tests_run++;
    if (r !== 4) begin tests_failed++; $display("FAIL arith_retires: got %0d expected 4", r); end
    tests_run++;
    if (n !== 10) begin tests_failed++; $display("FAIL arith_cycles: got %0d expected 10", n); end
    @(negedge clk);
    tests_run++;
    if (dut.d_q !== 16'd8 || dut.a_q !== 16'd3 || dut.pc_q !== 15'd4) begin
      tests_failed++;
      $display("FAIL arith_regs: d=%0h a=%0h pc=%0h expected 8 3 4", dut.d_q, dut.a_q, dut.pc_q);
    end
  endtask

  task automatic test_wait();
    int n = 0, r = 0, re_cyc = 0, bad = 0;
    bit started = 0;
    clear_mem();
    imem[0] = 16'h0007; imem[1] = 16'hFC10; dm[7] = 16'h1234;
    dmem_wait = 3;
    do_reset();
    for (int c = 0; c < 60 && r < 2; c++) begin
      @(negedge clk);
      if (bus.imem_req) started = 1;
      if (started) n++;
      if (retire) r++;
      if (bus.dmem_re) begin
        re_cyc++;
        if (bus.dmem_addr !== 15'd7) bad++;
      end
    end
    tests_run++;
    if (r !== 2) begin tests_failed++; $display("FAIL wait_retires: got %0d expected 2", r); end
    tests_run++;
    if (re_cyc !== 4) begin tests_failed++; $display("FAIL wait_re_cycles: got %0d expected 4", re_cyc); end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL wait_addr_stable: got %0d bad cycles expected 0", bad); end
    tests_run++;
    if (n !== 9) begin tests_failed++; $display("FAIL wait_cycles: got %0d expected 9", n); end
    @(negedge clk);
    tests_run++;
    if (dut.d_q !== 16'h1234) begin
      tests_failed++;
      $display("FAIL wait_d: got %0h expected 1234", dut.d_q);
    end
  endtask

  task automatic test_amd();
    int n = 0, r = 0, wcnt = 0, viol = 0;
    logic [14:0] waddr = '0;
    logic [15:0] wdata = '0;
    bit started = 0;
    clear_mem();
    imem[0] = 16'h0064; imem[1] = 16'hFDF8; dm[100] = 16'd41;
    do_reset();
    for (int c = 0; c < 60 && r < 2; c++) begin
      @(negedge clk);
      if (bus.imem_req) started = 1;
      if (started) n++;
      if (retire) r++;
      if (bus.dmem_we && bus.dmem_ready) begin
        wcnt++; waddr = bus.dmem_addr; wdata = bus.dmem_wdata;
      end
      if ((bus.dmem_re && bus.dmem_we) || (bus.imem_req && (bus.dmem_re || bus.dmem_we))) viol++;
    end
    tests_run++;
    if (wcnt !== 1 || waddr !== 15'd100 || wdata !== 16'd42) begin
      tests_failed++;
      $display("FAIL amd_write: count=%0d addr=%0d data=%0d expected 1 100 42", wcnt, waddr, wdata);
    end
    tests_run++;
    if (viol !== 0) begin tests_failed++; $display("FAIL amd_req_overlap: got %0d expected 0", viol); end
    tests_run++;
    if (n !== 7) begin tests_failed++; $display("FAIL amd_cycles: got %0d expected 7", n); end
    @(negedge clk);
    tests_run++;
    if (dut.a_q !== 16'd42 || dut.d_q !== 16'd42) begin
      tests_failed++;
      $display("FAIL amd_regs: a=%0d d=%0d expected 42 42", dut.a_q, dut.d_q);
    end
  endtask

  task automatic test_jumps();
    int fa [16];
    int exp_f [8] = '{0, 1, 2, 10, 11, 12, 13, 9};
    int nf = 0, bad = 0, quiet = 0, hcnt = 0;
    bit seen_halt = 0, prev_req = 0, prev_rdy = 0;
    logic [14:0] prev_addr = '0;
    clear_mem();
    imem[0] = 16'h000A; imem[1] = 16'hEE90; imem[2] = 16'hE304;
    imem[10] = 16'h0014; imem[11] = 16'hE301; imem[12] = 16'h0009; imem[13] = 16'hEA87;
    imem[9] = 16'hEA87;
    imem_wait = 1;
    do_reset();
    for (int c = 0; c < 150 && !seen_halt; c++) begin
      @(negedge clk);
      if (bus.imem_req && prev_req && !prev_rdy && bus.imem_addr !== prev_addr) bad++;
      if (bus.imem_req && bus.imem_ready && nf < 16) begin fa[nf] = int'(bus.imem_addr); nf++; end
      prev_req = bus.imem_req; prev_rdy = bus.imem_ready; prev_addr = bus.imem_addr;
      if (halted) seen_halt = 1;
    end
    tests_run++;
    if (!seen_halt) begin tests_failed++; $display("FAIL jump_halt_seen: got 0 expected 1"); end
    tests_run++;
    if (nf !== 8) begin tests_failed++; $display("FAIL jump_fetch_count: got %0d expected 8", nf); end
    for (int i = 0; i < 8 && i < nf; i++) begin
      tests_run++;
      if (fa[i] !== exp_f[i]) begin
        tests_failed++;
        $display("FAIL jump_fetch_addr[%0d]: got %0d expected %0d", i, fa[i], exp_f[i]);
      end
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL jump_fetch_stable: got %0d bad cycles expected 0", bad); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.imem_req || bus.dmem_re || bus.dmem_we) quiet++;
      if (halted) hcnt++;
    end
    tests_run++;
    if (quiet !== 0 || hcnt !== 10) begin
      tests_failed++;
      $display("FAIL jump_halt_hold: req_cycles=%0d halted_cycles=%0d expected 0 10", quiet, hcnt);
    end
    tests_run++;
    if (dut.pc_q !== 15'd9 || dut.d_q !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL jump_regs: pc=%0d d=%0h expected 9 ffff", dut.pc_q, dut.d_q);
    end
  endtask

  task automatic test_reset_mid_write();
    bit saw_we = 0;
    int held = 0;
    clear_mem();
    imem[0] = 16'h0005; imem[1] = 16'hE308;
    dforce = 1; dval = 0;
    do_reset();
    for (int c = 0; c < 30 && !saw_we; c++) begin
      @(negedge clk);
      if (bus.dmem_we) saw_we = 1;
    end
    tests_run++;
    if (!saw_we) begin tests_failed++; $display("FAIL midwr_we_seen: got 0 expected 1"); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (bus.dmem_we && bus.dmem_addr === 15'd5) held++;
    end
    tests_run++;
    if (held !== 2) begin tests_failed++; $display("FAIL midwr_we_hold: got %0d expected 2", held); end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.dmem_we !== 1'b0 || dut.pc_q !== 15'd0) begin
      tests_failed++;
      $display("FAIL midwr_reset: we=%b pc=%0d expected 0 0", bus.dmem_we, dut.pc_q);
    end
    reset = 1'b1;
    dforce = 0;
    @(negedge clk);
    tests_run++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 15'd0 || bus.dmem_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL midwr_refetch: req=%b addr=%0d we=%b expected 1 0 0",
               bus.imem_req, bus.imem_addr, bus.dmem_we);
    end
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_arith();
    test_wait();
    test_amd();
    test_jumps();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
